// File: rtl/rotate_sweep_sequencer.sv
// Sweeps one operand through every shift amount of an external barrel shifter.
// Each amount is held for DWELL cycles; the shifter result is then captured and folded into a running XOR.
module rotate_sweep_sequencer #(
  parameter int N     = 3,
  parameter int DWELL = 4,
  localparam int W    = 2**N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] num_in,
  input  logic         dir_in,
  output logic [W-1:0] num_o,
  output logic [N-1:0] shift_o,
  output logic         select_o,
  input  logic [W-1:0] result_i,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic [N-1:0] res_shift,
  output logic [W-1:0] sig,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  localparam logic [7:0]   DW_LAST = 8'(DWELL - 1);
  localparam logic [N-1:0] SH_LAST = '1;
  localparam logic [N-1:0] SH_ONE  = N'(1);

  state_t     state;
  logic [7:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      num_o     <= '0;
      shift_o   <= '0;
      select_o  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_shift <= '0;
      sig       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          // start has priority over abort here; abort alone is a no-op
          if (start) begin
            num_o    <= num_in;
            select_o <= dir_in;
            shift_o  <= '0;
            cnt      <= '0;
            sig      <= '0;
            busy     <= 1'b1;
            state    <= STEP;
          end
        end
        STEP: begin
          if (abort) begin
            shift_o <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (cnt == DW_LAST) begin
            res_data  <= result_i;
            res_shift <= shift_o;
            res_valid <= 1'b1;
            sig       <= sig ^ result_i;
            cnt       <= '0;
            // last amount: hold shift_o at its max rather than wrapping
            if (shift_o == SH_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              shift_o <= shift_o + SH_ONE;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          if (abort) begin
            shift_o <= '0;
            cnt     <= '0;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_sweep_sequencer.sv
// Bench for rotate_sweep_sequencer: the barrel shifter is modelled as a rotate,
// and expected captures come from a per-cycle schedule computed arithmetically.
module tb_rotate_sweep_sequencer;

  localparam int D4 = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       start, abort, dir_in;
  logic [7:0] num_in;
  logic [7:0] num_o, res_data, sig, result_i;
  logic [2:0] shift_o, res_shift;
  logic       select_o, res_valid, busy, done;

  logic       start1, abort1, dir_in1;
  logic [7:0] num_in1;
  logic [7:0] num_o1, res_data1, sig1, result_i1;
  logic [2:0] shift_o1, res_shift1;
  logic       select_o1, res_valid1, busy1, done1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rot(input logic [7:0] v, input int k, input logic left);
    logic [15:0] t;
    t = {v, v};
    if (left) begin
      t = t << k;
      return t[15:8];
    end
    t = t >> k;
    return t[7:0];
  endfunction

  assign result_i  = rot(num_o,  int'(shift_o),  select_o);
  assign result_i1 = rot(num_o1, int'(shift_o1), select_o1);

  rotate_sweep_sequencer #(.N(3), .DWELL(D4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_in(num_in), .dir_in(dir_in), .num_o(num_o), .shift_o(shift_o),
    .select_o(select_o), .result_i(result_i), .res_valid(res_valid),
    .res_data(res_data), .res_shift(res_shift), .sig(sig), .busy(busy), .done(done)
  );

  rotate_sweep_sequencer #(.N(3), .DWELL(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .num_in(num_in1), .dir_in(dir_in1), .num_o(num_o1), .shift_o(shift_o1),
    .select_o(select_o1), .result_i(result_i1), .res_valid(res_valid1),
    .res_data(res_data1), .res_shift(res_shift1), .sig(sig1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drives one DWELL=4 sweep and checks every cycle against the capture schedule.
  // restart_at/abort_at: cycle in which start(0xFF)/abort is held (0 = never).
  // stop_at: return right after checking that cycle, leaving the sweep running.
  task automatic run_sweep(input logic [7:0] num, input logic dir, input int restart_at,
                           input int abort_at, input int stop_at, input bit abort0,
                           output logic [7:0] first, output logic [7:0] last,
                           output logic [7:0] fsig);
    int         t_done;
    int         last_c;
    int         ncap;
    logic [7:0] esig, edata;
    logic [2:0] eshift;
    t_done = 8 * D4 + 1;
    last_c = (abort_at > 0) ? abort_at + 2 : t_done + 2;
    ncap   = 0;
    esig   = '0;
    edata  = '0;
    eshift = '0;
    first  = '0;
    last   = '0;
    @(negedge clk);
    start = 1'b1; abort = abort0; num_in = num; dir_in = dir;
    for (int c = 1; c <= last_c; c++) begin
      bit alive, ev;
      @(negedge clk);
      alive = (abort_at == 0) || (c <= abort_at);
      ev    = alive && ((c - 1) % D4 == 0) && (c - 1 >= D4) && (c - 1 <= 8 * D4);
      if (ev) begin
        edata  = rot(num, ncap, dir);
        eshift = 3'(ncap);
        esig   = esig ^ edata;
        if (ncap == 0) first = edata;
        last = edata;
        ncap++;
      end
      chk($sformatf("res_valid c%0d", c), 32'(res_valid), 32'(ev));
      chk($sformatf("busy c%0d", c), 32'(busy), 32'(alive && c <= t_done));
      chk($sformatf("done c%0d", c), 32'(done), 32'(alive && c == t_done));
      chk($sformatf("sig c%0d", c), 32'(sig), 32'(esig));
      chk($sformatf("num_o c%0d", c), 32'(num_o), 32'(num));
      chk($sformatf("select_o c%0d", c), 32'(select_o), 32'(dir));
      if (ncap > 0) begin
        chk($sformatf("res_data c%0d", c), 32'(res_data), 32'(edata));
        chk($sformatf("res_shift c%0d", c), 32'(res_shift), 32'(eshift));
      end
      if (alive && c <= 8 * D4) chk($sformatf("shift_o c%0d", c), 32'(shift_o), 32'((c - 1) / D4));
      if (!alive) chk($sformatf("shift_o abort c%0d", c), 32'(shift_o), 32'(0));
      if (c == stop_at) begin
        start = 1'b0; abort = 1'b0; fsig = esig;
        return;
      end
      start  = (c == restart_at);
      num_in = start ? 8'hFF : ~num;
      abort  = (c == abort_at);
    end
    start = 1'b0; abort = 1'b0;
    fsig = esig;
  endtask

  typedef struct {
    logic [7:0] num;
    logic       dir;
    logic [7:0] first;
    logic [7:0] last;
    logic [7:0] sig;
  } vec_t;

  initial begin
    vec_t       tbl[6];
    logic [7:0] f, l, s;

    tbl[0] = '{8'hD2, 1'b0, 8'hD2, 8'hA5, 8'h00};
    tbl[1] = '{8'h01, 1'b1, 8'h01, 8'h80, 8'hFF};
    tbl[2] = '{8'h01, 1'b0, 8'h01, 8'h02, 8'hFF};
    tbl[3] = '{8'h80, 1'b1, 8'h80, 8'h40, 8'hFF};
    tbl[4] = '{8'h3C, 1'b1, 8'h3C, 8'h1E, 8'h00};
    tbl[5] = '{8'hFF, 1'b0, 8'hFF, 8'hFF, 8'h00};

    start = 0; abort = 0; dir_in = 0; num_in = 0;
    start1 = 0; abort1 = 0; dir_in1 = 0; num_in1 = 0;

    #12;
    chk("reset num_o", 32'(num_o), 0);
    chk("reset shift_o", 32'(shift_o), 0);
    chk("reset select_o", 32'(select_o), 0);
    chk("reset res_valid", 32'(res_valid), 0);
    chk("reset res_data", 32'(res_data), 0);
    chk("reset sig", 32'(sig), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_sweep(tbl[i].num, tbl[i].dir, 0, 0, 0, 1'b0, f, l, s);
      chk($sformatf("tbl%0d first", i), 32'(f), 32'(tbl[i].first));
      chk($sformatf("tbl%0d last", i), 32'(l), 32'(tbl[i].last));
      chk($sformatf("tbl%0d sig", i), 32'(sig), 32'(tbl[i].sig));
      chk($sformatf("tbl%0d model sig", i), 32'(s), 32'(tbl[i].sig));
    end

    // abort while idle: nothing moves, captures retained
    run_sweep(8'h01, 1'b1, 0, 0, 0, 1'b0, f, l, s);
    @(negedge clk); abort = 1'b1;
    @(negedge clk);
    @(negedge clk); abort = 1'b0;
    chk("idle abort busy", 32'(busy), 0);
    chk("idle abort sig", 32'(sig), 32'hFF);
    chk("idle abort res_data", 32'(res_data), 32'h80);
    chk("idle abort res_shift", 32'(res_shift), 7);

    // restart ignored mid-sweep
    run_sweep(8'hD2, 1'b0, 10, 0, 0, 1'b0, f, l, s);
    chk("restart sig", 32'(sig), 0);

    // abort after three captures
    run_sweep(8'hD2, 1'b0, 0, 14, 0, 1'b0, f, l, s);
    chk("abort sig", 32'(sig), 32'h0F);

    // start and abort together in idle: start wins
    run_sweep(8'h3C, 1'b1, 0, 0, 0, 1'b1, f, l, s);
    chk("start+abort sig", 32'(sig), 0);

    // asynchronous reset in the middle of cycle 20
    run_sweep(8'hD2, 1'b0, 0, 0, 20, 1'b0, f, l, s);
    #1 reset = 1'b1;
    #1;
    chk("mid reset num_o", 32'(num_o), 0);
    chk("mid reset shift_o", 32'(shift_o), 0);
    chk("mid reset select_o", 32'(select_o), 0);
    chk("mid reset res_valid", 32'(res_valid), 0);
    chk("mid reset res_data", 32'(res_data), 0);
    chk("mid reset res_shift", 32'(res_shift), 0);
    chk("mid reset sig", 32'(sig), 0);
    chk("mid reset busy", 32'(busy), 0);
    chk("mid reset done", 32'(done), 0);
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post reset busy %0d", c), 32'(busy), 0);
      chk($sformatf("post reset done %0d", c), 32'(done), 0);
    end
    run_sweep(8'hD2, 1'b0, 0, 0, 0, 1'b0, f, l, s);
    chk("post reset last", 32'(l), 32'hA5);

    // randomized sweeps, some with an abort at a random cycle
    for (int i = 0; i < 8; i++) begin
      logic [7:0] rn;
      logic       rd;
      int         ra;
      rn = 8'($urandom);
      rd = 1'($urandom);
      ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 33)) : 0;
      run_sweep(rn, rd, 0, ra, 0, 1'b0, f, l, s);
    end

    // DWELL=1: back-to-back captures in cycles 2..9
    @(negedge clk);
    start1 = 1'b1; num_in1 = 8'hD2; dir_in1 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      bit ev;
      @(negedge clk);
      start1 = 1'b0;
      ev = (c >= 2) && (c <= 9);
      chk($sformatf("d1 res_valid c%0d", c), 32'(res_valid1), 32'(ev));
      chk($sformatf("d1 done c%0d", c), 32'(done1), 32'(c == 9));
      chk($sformatf("d1 busy c%0d", c), 32'(busy1), 32'(c <= 9));
      if (ev) begin
        chk($sformatf("d1 res_data c%0d", c), 32'(res_data1), 32'(rot(8'hD2, c - 2, 1'b0)));
        chk($sformatf("d1 res_shift c%0d", c), 32'(res_shift1), 32'(c - 2));
      end
    end
    chk("d1 sig", 32'(sig1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rotate_sweep_sequencer.md
ROTATE_SWEEP_SEQUENCER -- requirements
Module: rotate_sweep_sequencer

Interface
REQ-001 Parameter N, default 3, meaning shift-amount width; data width W = 2**N (8 at default).
REQ-002 Parameter DWELL, default 4, meaning cycles each shift amount is held (legal range 1..255).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a sweep.
REQ-006 abort  input  1  synchronous request to cancel a running sweep.
REQ-007 num_in  input  W  operand to sweep.
REQ-008 dir_in  input  1  rotate direction for the sweep; driven unchanged onto select_o.
REQ-009 num_o  output  W  operand to the downstream barrel shifter.
REQ-010 shift_o  output  N  shift amount to the downstream barrel shifter.
REQ-011 select_o  output  1  direction select to the downstream barrel shifter.
REQ-012 result_i  input  W  combinational result returned by the barrel shifter.
REQ-013 res_valid  output  1  one-cycle strobe: res_data/res_shift hold a new capture.
REQ-014 res_data  output  W  captured result_i.
REQ-015 res_shift  output  N  shift amount that produced res_data.
REQ-016 sig  output  W  running XOR of all captures in the current sweep.
REQ-017 busy  output  1  high while a sweep is in progress (STEP or DONE).
REQ-018 done  output  1  one-cycle strobe at sweep completion.

Function
REQ-019 FSM states SHALL be IDLE, STEP, DONE.
REQ-020 IDLE: start=1 at an edge latches num_in into num_o, dir_in into select_o, clears shift_o, dwell counter and sig, and enters STEP.
REQ-021 start while busy=1 SHALL be ignored; num_o/select_o SHALL not change during a sweep.
REQ-022 STEP: dwell counter increments each cycle; when counter==DWELL-1 at an edge, result_i is captured into res_data, shift_o into res_shift, sig<=sig^result_i, and res_valid is 1 for the following cycle only.
REQ-023 On that capture edge, if shift_o<2**N-1 then shift_o increments and counter clears; if shift_o==2**N-1 the FSM enters DONE (no wrap of shift_o).
REQ-024 DONE: done=1 and busy=1 for exactly one cycle, then IDLE; res_data, res_shift, sig retain values in IDLE.
REQ-025 Timing: start sampled at edge 0 -> STEP for 2**N*DWELL cycles (1..32 at defaults); res_valid in cycles DWELL+1, 2*DWELL+1, ...; last res_valid and done both in cycle 2**N*DWELL+1; busy=0 from the next cycle.
REQ-026 DWELL=1: a capture on every STEP cycle, giving consecutive res_valid pulses.
REQ-027 abort=1 in STEP or DONE: next state IDLE, shift_o and counter cleared, no res_valid and no done that cycle; sig keeps its partial value; abort in IDLE has no effect.
REQ-028 abort and a capture on the same edge: abort wins, no capture.
REQ-029 start and abort both high in IDLE: start wins.

Reset
REQ-030 reset=1 SHALL immediately force IDLE and zero num_o, shift_o, select_o, res_valid, res_data, res_shift, sig, busy, done and the dwell counter, regardless of clk.
REQ-031 reset asserted mid-sweep SHALL abort it with no done; after release the block waits for a new start.

Verification (bench models the shifter as a rotate: select 0 = right, 1 = left)
REQ-032 num_in=0xD2, dir_in=0, start pulse, DWELL=4 -> res_shift 0..7 with res_data 0xD2,0x69,0xB4,0x5A,0x2D,0x96,0x4B,0xA5; done at cycle 33; sig=0x00.
REQ-033 num_in=0x01, dir_in=1 -> res_data 0x01,0x02,0x04,...,0x80; sig=0xFF; select_o=1 throughout.
REQ-034 start re-pulsed in cycle 10 with num_in=0xFF -> ignored; num_o stays 0xD2 and the sweep completes unchanged.
REQ-035 abort in cycle 14 (after 3 captures) -> busy=0 next cycle, no done, sig=0xD2^0x69^0xB4=0x0F.
REQ-036 reset asserted asynchronously mid-cycle in cycle 20 -> all outputs zero before the next edge; a subsequent start runs a full, correct sweep.
REQ-037 DWELL=1, num_in=0xD2 -> eight consecutive res_valid cycles 2..9, done in cycle 9.
